axil_adder_array: RTL and testbench
===================================

AXIL_ADDER_ARRAY -- requirements
Module: axil_adder_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register/data width in bits (8-aligned, 8..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, AXI4-Lite byte-address width (>=7).
REQ-003 SHALL have parameter N_CH, default 4, number of independent adder channels (1..7).
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- s1_axi_aclk  in  1  sole clock; all state changes on rising edge.
- s1_axi_areset  in  1  synchronous, active-high reset.
REQ-005 SHALL have the following write-channel ports:
- s1_axi_awaddr  in  ADDR_WIDTH  write address.
- s1_axi_awvalid in 1 / s1_axi_awready out 1  AW handshake.
- s1_axi_wdata  in  DATA_WIDTH  write data.
- s1_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s1_axi_wvalid in 1 / s1_axi_wready out 1  W handshake.
- s1_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR).
- s1_axi_bvalid out 1 / s1_axi_bready in 1  B handshake.
REQ-006 SHALL have the following read-channel ports:
- s1_axi_araddr  in  ADDR_WIDTH  read address.
- s1_axi_arvalid in 1 / s1_axi_arready out 1  AR handshake.
- s1_axi_rdata  out  DATA_WIDTH  read data.
- s1_axi_rresp  out  2  read response (00 OKAY, 10 SLVERR).
- s1_axi_rvalid out 1 / s1_axi_rready in 1  R handshake.

Function
REQ-007 SHALL decode addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. Channel c (0..N_CH-1) occupies base c*0x10: +0x0 A (RW), +0x4 B (RW), +0x8 SUM (RO), +0xC STATUS (bit0 OVF sticky, W1C). CTRL at 0x70 (RW): bit0 ACC, bit1 SAT; other bits read 0.
REQ-008 SHALL treat any other address as unmapped: read -> RDATA 0, RRESP 10; write -> BRESP 10, no state change. Write to SUM -> BRESP 10, no change.
REQ-009 Write FSM SHALL use states IDLE, WAIT_W, WAIT_AW, RESP: AWREADY high in IDLE/WAIT_AW, WREADY high in IDLE/WAIT_W; AW-only handshake -> WAIT_W; W-only -> WAIT_AW; both (same or completing cycle) -> RESP.
REQ-010 On entry to RESP, the write SHALL commit on the same edge BVALID rises (one cycle after the last of AW/W handshakes); BVALID and BRESP SHALL hold until BREADY; BVALID&&BREADY -> IDLE; no back-to-back acceptance while in RESP.
REQ-011 Writes to A, B, CTRL SHALL update only bytes with wstrb set; STATUS write clears OVF when wdata[0]=1 regardless of wstrb.
REQ-012 Read FSM SHALL use states IDLE, DATA: ARREADY high only in IDLE; AR handshake captures register value into RDATA and raises RVALID next edge; RDATA/RRESP hold until RREADY; RVALID&&RREADY -> IDLE.
REQ-013 Read and write FSMs SHALL be independent; a read captured on the same edge a write commits SHALL return the pre-write value.
REQ-014 ACC=0: SUM_c SHALL be recomputed from A_c+B_c one cycle after any commit to A_c or B_c (unsigned, DATA_WIDTH+1-bit intermediate).
REQ-015 ACC=1: commit to A_c SHALL set SUM_c <= SUM_c + new A_c one cycle later; commit to B_c SHALL set SUM_c <= B_c (preload) one cycle later.
REQ-016 On carry-out: SAT=1 -> SUM = all ones; SAT=0 -> SUM wraps modulo 2^DATA_WIDTH; OVF_c set in both cases.
REQ-017 OVF set and W1C clear on the same edge SHALL leave OVF=1.
REQ-018 Changing CTRL SHALL not retroactively alter SUM; new mode applies to subsequent A/B commits.

Reset
REQ-019 On s1_axi_aclk edge with s1_axi_areset=1: all registers (A, B, SUM, STATUS, CTRL) = 0, both FSMs -> IDLE, AWREADY/WREADY/ARREADY = 0, BVALID = RVALID = 0, BRESP = RRESP = 00, RDATA = 0; READY outputs assert the first cycle after reset deasserts.
REQ-020 Reset asserted mid-transaction SHALL abort it with no commit and no response.

Verification
REQ-021 Write A0=39, B0=40 (wstrb 0xF), read 0x08 -> RDATA 79, RRESP 00, each BRESP 00.
REQ-022 W before AW by 3 cycles, addr 0x14 data 5 -> single BVALID, B1=5; AW before W likewise -> same result.
REQ-023 CTRL=0, A2=0xFFFFFFFF, B2=2 -> SUM 1, STATUS 1; CTRL=2, rewrite B2=2 -> SUM 0xFFFFFFFF; write STATUS=1 -> STATUS 0.
REQ-024 CTRL=1, B3=10 then A3=5, A3=7 -> SUM3 22; wstrb 0x1 write 0xFF to A0 holding 0x12345678 -> A0 0x123456FF.
REQ-025 Write 0x23 and 0x08, read 0x7C -> BRESP/RRESP 10, RDATA 0, no register changed; BREADY held low 5 cycles -> BVALID held, AWREADY low.
REQ-026 Assert s1_axi_areset during RESP and during DATA -> BVALID=RVALID=0 next cycle, all registers 0.

Source files
------------

// File: rtl/axil_adder_array.sv
`default_nettype none
// ============================================================================
// Module  : axil_adder_array
// Brief   : AXI4-Lite slave with N_CH adder channels (A, B, SUM, STATUS) and
//           a shared CTRL register selecting accumulate and saturate modes.
// Revision: 1.0
// ============================================================================
module axil_adder_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int N_CH       = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CHA_W  = ADDR_WIDTH - 4;
  localparam logic [ADDR_WIDTH-3:0] CTRL_WORD = (ADDR_WIDTH-2)'(28);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic ch_match(input logic [ADDR_WIDTH-1:0] addr, input int c);
    return addr[ADDR_WIDTH-1:4] == CHA_W'(c);
  endfunction

  function automatic logic is_ctrl(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:2] == CTRL_WORD;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0] old_v,
                                                       input logic [DATA_WIDTH-1:0] new_v,
                                                       input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Register file
  logic [DATA_WIDTH-1:0] a_q   [N_CH];
  logic [DATA_WIDTH-1:0] b_q   [N_CH];
  logic [DATA_WIDTH-1:0] sum_q [N_CH];
  logic [DATA_WIDTH-1:0] sum_d [N_CH];
  logic [DATA_WIDTH:0]   sum_ext [N_CH];
  logic [N_CH-1:0]       ovf_q;
  logic [N_CH-1:0]       pend_a_q;
  logic [N_CH-1:0]       pend_b_q;
  logic [1:0]            ctrl_q;

  // Write channel
  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_W  = 2'd1,
    W_WAIT_AW = 2'd2,
    W_RESP    = 2'd3
  } wstate_e;

  wstate_e               wstate_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  c_err;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;

  assign aw_hs = s1_axi_awvalid && awready_q;
  assign w_hs  = s1_axi_wvalid && wready_q;

  // The commit uses whichever half arrives live on the completing edge and
  // the captured copy of the half that arrived earlier.
  always_comb begin
    commit = 1'b0;
    c_addr = awaddr_q;
    c_data = wdata_q;
    c_strb = wstrb_q;
    case (wstate_q)
      W_IDLE: begin
        commit = aw_hs && w_hs;
        c_addr = s1_axi_awaddr;
        c_data = s1_axi_wdata;
        c_strb = s1_axi_wstrb;
      end
      W_WAIT_W: begin
        commit = w_hs;
        c_data = s1_axi_wdata;
        c_strb = s1_axi_wstrb;
      end
      W_WAIT_AW: begin
        commit = aw_hs;
        c_addr = s1_axi_awaddr;
      end
      default: ;
    endcase
  end

  always_comb begin
    c_err = !is_ctrl(c_addr);
    for (int c = 0; c < N_CH; c++) begin
      if (ch_match(c_addr, c) && (c_addr[3:2] != 2'd2)) c_err = 1'b0;
    end
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (commit) begin
            wstate_q  <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= c_err ? RESP_SLVERR : RESP_OKAY;
          end else if (aw_hs) begin
            wstate_q  <= W_WAIT_W;
            awaddr_q  <= s1_axi_awaddr;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            wstate_q  <= W_WAIT_AW;
            wdata_q   <= s1_axi_wdata;
            wstrb_q   <= s1_axi_wstrb;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_WAIT_W, W_WAIT_AW: begin
          if (commit) begin
            wstate_q  <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= c_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: begin
          if (s1_axi_bready) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Mode is sampled on the update edge; no other commit can land in between.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      if (!ctrl_q[0])      sum_ext[c] = {1'b0, a_q[c]} + {1'b0, b_q[c]};
      else if (pend_b_q[c]) sum_ext[c] = {1'b0, b_q[c]};
      else                  sum_ext[c] = {1'b0, sum_q[c]} + {1'b0, a_q[c]};
      sum_d[c] = (sum_ext[c][DATA_WIDTH] && ctrl_q[1]) ? '1 : sum_ext[c][DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      for (int c = 0; c < N_CH; c++) begin
        a_q[c]   <= '0;
        b_q[c]   <= '0;
        sum_q[c] <= '0;
      end
      ovf_q    <= '0;
      pend_a_q <= '0;
      pend_b_q <= '0;
      ctrl_q   <= '0;
    end else begin
      pend_a_q <= '0;
      pend_b_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        if (commit && !c_err && ch_match(c_addr, c)) begin
          case (c_addr[3:2])
            2'd0: begin
              a_q[c]      <= merge_strb(a_q[c], c_data, c_strb);
              pend_a_q[c] <= 1'b1;
            end
            2'd1: begin
              b_q[c]      <= merge_strb(b_q[c], c_data, c_strb);
              pend_b_q[c] <= 1'b1;
            end
            2'd3: if (c_data[0]) ovf_q[c] <= 1'b0;
            default: ;
          endcase
        end
        // Set is placed after the W1C clear so a coincident set wins.
        if (pend_a_q[c] || pend_b_q[c]) begin
          sum_q[c] <= sum_d[c];
          if (sum_ext[c][DATA_WIDTH]) ovf_q[c] <= 1'b1;
        end
      end
      if (commit && !c_err && is_ctrl(c_addr) && c_strb[0]) ctrl_q <= c_data[1:0];
    end
  end

  // Read channel
  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  rstate_e               rstate_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    if (is_ctrl(s1_axi_araddr)) begin
      rd_data = DATA_WIDTH'(ctrl_q);
      rd_err  = 1'b0;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (ch_match(s1_axi_araddr, c)) begin
        rd_err = 1'b0;
        case (s1_axi_araddr[3:2])
          2'd0:    rd_data = a_q[c];
          2'd1:    rd_data = b_q[c];
          2'd2:    rd_data = sum_q[c];
          default: rd_data = DATA_WIDTH'(ovf_q[c]);
        endcase
      end
    end
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (s1_axi_arvalid && arready_q) begin
            rstate_q  <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data;
            rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s1_axi_rready) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s1_axi_awready = awready_q;
  assign s1_axi_wready  = wready_q;
  assign s1_axi_bvalid  = bvalid_q;
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = arready_q;
  assign s1_axi_rvalid  = rvalid_q;
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_adder_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_axil_adder_array
// Brief   : Directed self-checking bench for axil_adder_array.
// Revision: 1.0
// ============================================================================
module tb_axil_adder_array;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  int errors = 0;
  int checks = 0;

  axil_adder_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CH(4)) u_dut (
    .s1_axi_aclk    (clk),
    .s1_axi_areset  (rst),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Starts on a negedge, returns on the negedge after the B handshake.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int hold, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_hit;
    bit w_hit;
    int cyc = 0;
    int n = 0;
    @(negedge clk);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    bready = (hold == 0);
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hit  = awvalid && awready;
      w_hit   = wvalid && wready;
      @(negedge clk);
      aw_done = aw_done || aw_hit;
      w_done  = w_done || w_hit;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("wr_handshake_done", 64'(aw_done && w_done), 64'd1);
    while (!bvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bvalid_seen", 64'(bvalid), 64'd1);
    resp = bresp;
    for (int i = 0; i < hold; i++) begin
      check("bvalid_held", 64'(bvalid), 64'd1);
      check("awready_low_in_resp", 64'(awready), 64'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    bit hit = 0;
    int n = 0;
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b1;
    while (!hit && n < 100) begin
      hit = arready;
      @(negedge clk);
      n++;
    end
    arvalid = 1'b0;
    check("rd_handshake_done", 64'(hit), 64'd1);
    n = 0;
    while (!rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rvalid_seen", 64'(rvalid), 64'd1);
    data = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  task automatic wr_ok(input string tag, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [3:0] strb);
    logic [1:0] r;
    axi_write(addr, data, strb, 0, 0, 0, r);
    check(tag, 64'(r), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    logic [1:0]    r;
    axi_read(addr, d, r);
    check(tag, 64'(d), 64'(exp));
    check({tag, "_rresp"}, 64'(r), 64'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(awready && wready && arready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_reset", 64'(awready && wready && arready), 64'd1);
  endtask

  initial begin
    logic [1:0]    resp;
    logic [DW-1:0] data;
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_bresp_rresp", 64'({bresp, rresp}), 64'd0);
    rst = 1'b0;

    // Basic add
    wr_ok("wr_a0", 8'h00, 32'd39, 4'hF);
    wr_ok("wr_b0", 8'h04, 32'd40, 4'hF);
    rd_chk("sum0_79", 8'h08, 32'd79);

    // W leads AW by three cycles, then AW leads W
    axi_write(8'h14, 32'd5, 4'hF, 3, 0, 0, resp);
    check("wfirst_bresp", 64'(resp), 64'd0);
    check("wfirst_single_bvalid", 64'(bvalid), 64'd0);
    rd_chk("b1_wfirst", 8'h14, 32'd5);
    wr_ok("clr_b1", 8'h14, 32'd0, 4'hF);
    rd_chk("b1_cleared", 8'h14, 32'd0);
    axi_write(8'h14, 32'd5, 4'hF, 0, 3, 0, resp);
    check("awfirst_bresp", 64'(resp), 64'd0);
    check("awfirst_single_bvalid", 64'(bvalid), 64'd0);
    rd_chk("b1_awfirst", 8'h14, 32'd5);
    rd_chk("sum1", 8'h18, 32'd5);

    // Wrap, saturate and W1C on channel 2
    wr_ok("ctrl_0", 8'h70, 32'd0, 4'hF);
    wr_ok("wr_a2", 8'h20, 32'hFFFF_FFFF, 4'hF);
    wr_ok("wr_b2", 8'h24, 32'd2, 4'hF);
    rd_chk("sum2_wrap", 8'h28, 32'd1);
    rd_chk("status2_set", 8'h2C, 32'd1);
    wr_ok("ctrl_sat", 8'h70, 32'd2, 4'hF);
    rd_chk("ctrl_rd_2", 8'h70, 32'd2);
    wr_ok("wr_b2_again", 8'h24, 32'd2, 4'hF);
    rd_chk("sum2_sat", 8'h28, 32'hFFFF_FFFF);
    rd_chk("status2_still", 8'h2C, 32'd1);
    wr_ok("status2_w1c", 8'h2C, 32'd1, 4'hF);
    rd_chk("status2_clr", 8'h2C, 32'd0);

    // Accumulate on channel 3, then byte strobes on A0
    wr_ok("ctrl_acc", 8'h70, 32'd1, 4'hF);
    wr_ok("wr_b3", 8'h34, 32'd10, 4'hF);
    wr_ok("wr_a3_5", 8'h30, 32'd5, 4'hF);
    wr_ok("wr_a3_7", 8'h30, 32'd7, 4'hF);
    rd_chk("sum3_acc", 8'h38, 32'd22);
    rd_chk("status3", 8'h3C, 32'd0);
    wr_ok("ctrl_off", 8'h70, 32'd0, 4'hF);
    wr_ok("wr_a0_full", 8'h00, 32'h1234_5678, 4'hF);
    wr_ok("wr_a0_byte", 8'h00, 32'h0000_00FF, 4'h1);
    rd_chk("a0_strb", 8'h00, 32'h1234_56FF);
    rd_chk("sum0_after_strb", 8'h08, 32'h1234_5727);

    // Error responses; 0x23 aliases A2 since the low address bits are
    // ignored, so 0x74 serves as the unmapped write target.
    axi_write(8'h74, 32'h0000_DEAD, 4'hF, 0, 0, 5, resp);
    check("unmapped_bresp", 64'(resp), 64'd2);
    axi_write(8'h08, 32'h0000_1234, 4'hF, 0, 0, 0, resp);
    check("sum_write_bresp", 64'(resp), 64'd2);
    axi_read(8'h7C, data, resp);
    check("unmapped_rdata", 64'(data), 64'd0);
    check("unmapped_rresp", 64'(resp), 64'd2);
    rd_chk("sum0_unchanged", 8'h08, 32'h1234_5727);
    rd_chk("a0_unchanged", 8'h00, 32'h1234_56FF);
    rd_chk("ctrl_unchanged", 8'h70, 32'd0);
    wr_ok("ctrl_all_ones", 8'h70, 32'hFFFF_FFFF, 4'hF);
    rd_chk("ctrl_upper_zero", 8'h70, 32'd3);
    wr_ok("ctrl_clear", 8'h70, 32'd0, 4'hF);

    // Reset while a read response is pending
    @(negedge clk);
    rready  = 1'b0;
    araddr  = 8'h08;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_before_reset", 64'(rvalid), 64'd1);
    check("rdata_before_reset", 64'(rdata), 64'h1234_5727);
    rst = 1'b1;
    @(negedge clk);
    check("rvalid_after_reset", 64'(rvalid), 64'd0);
    check("rdata_after_reset", 64'(rdata), 64'd0);
    rst    = 1'b0;
    rready = 1'b1;
    wait_ready();

    // Reset while a write response is pending
    bready  = 1'b0;
    awaddr  = 8'h10;
    wdata   = 32'h55;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bvalid_before_reset", 64'(bvalid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("bvalid_after_reset", 64'(bvalid), 64'd0);
    rst    = 1'b0;
    bready = 1'b1;
    wait_ready();
    rd_chk("post_rst_a0", 8'h00, 32'd0);
    rd_chk("post_rst_b0", 8'h04, 32'd0);
    rd_chk("post_rst_sum0", 8'h08, 32'd0);
    rd_chk("post_rst_a1", 8'h10, 32'd0);
    rd_chk("post_rst_sum2", 8'h28, 32'd0);
    rd_chk("post_rst_ctrl", 8'h70, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
